tb_mem_lat: RTL

Parametrised successor to the testbench byte-addressed data memory model used by the central processing unit benches. It adds a configurable response latency, a `mem_to_cpu__ready` acceptance handshake and bounds checking with distinct error codes. Invalid `dtype` values are explicitly rejected. It sits on the CPU's memory port in simulation only and keeps the existing `cpu_to_mem__*` / `mem_to_cpu__*` protocol and `dtype` encoding.

---
 rtl/tb_mem_lat_if.sv | 32 +++
 rtl/tb_mem_lat.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/tb_mem_lat_if.sv
// Memory port between a CPU bench and the latency memory model.
// Handshake: a request transfers on a rising clk edge where
// cpu_to_mem__valid and mem_to_cpu__ready are both high. The request fields
// only need to be stable for that edge. mem_to_cpu__valid is a one-cycle
// response strobe with no back-pressure. mem_to_cpu__error and
// mem_to_cpu__data are meaningful only while mem_to_cpu__valid is high, and
// they read 0 otherwise.
interface tb_mem_lat_if;
    logic        cpu_to_mem__valid;
    logic        cpu_to_mem__we;
    logic [63:0] cpu_to_mem__addr;
    logic [2:0]  cpu_to_mem__dtype;
    logic [63:0] cpu_to_mem__data;
    logic        mem_to_cpu__ready;
    logic        mem_to_cpu__valid;
    logic        mem_to_cpu__error;
    logic [63:0] mem_to_cpu__data;

    modport master (
        output cpu_to_mem__valid, cpu_to_mem__we, cpu_to_mem__addr,
               cpu_to_mem__dtype, cpu_to_mem__data,
        input  mem_to_cpu__ready, mem_to_cpu__valid, mem_to_cpu__error,
               mem_to_cpu__data
    );

    modport slave (
        input  cpu_to_mem__valid, cpu_to_mem__we, cpu_to_mem__addr,
               cpu_to_mem__dtype, cpu_to_mem__data,
        output mem_to_cpu__ready, mem_to_cpu__valid, mem_to_cpu__error,
               mem_to_cpu__data
    );
endinterface

// File: rtl/tb_mem_lat.sv
// Byte-addressed data memory model with configurable response latency,
// bounds checking and distinct error codes.
// Error codes: 1 = misaligned, 2 = out of range, 3 = invalid dtype.
module tb_mem_lat #(
    parameter int DEPTH       = 4096,
    parameter int DEPTH__LOG2 = 12,
    parameter int LATENCY     = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    tb_mem_lat_if.slave  bus,
    output logic [1:0]   dbg_state
);
    localparam int AW = DEPTH__LOG2;
    localparam logic [AW:0] DEPTH_W = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_READY   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        ready_q;
    logic        valid_q;
    logic        req_we;
    logic [63:0] req_addr;
    logic [2:0]  req_dtype;
    logic [63:0] req_data;

    // Contents are deliberately not reset; unwritten bytes read X.
    logic [7:0]  mem [DEPTH];

    logic [AW-1:0] idx;
    logic [3:0]    size;
    logic [AW:0]   size_ext;
    logic [AW:0]   end_addr;
    logic          misalign;
    logic          oob;
    logic [63:0]   raw;
    logic [63:0]   rd_data;
    logic          resp_err;
    logic [63:0]   resp_data;

    // Request FSM: accept in READY, count down LATENCY, strobe one response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_READY;
            cnt       <= 4'd0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= 64'd0;
            req_dtype <= 3'd0;
            req_data  <= 64'd0;
        end else begin
            case (state)
                ST_READY: begin
                    if (bus.cpu_to_mem__valid) begin
                        req_we    <= bus.cpu_to_mem__we;
                        req_addr  <= bus.cpu_to_mem__addr;
                        req_dtype <= bus.cpu_to_mem__dtype;
                        req_data  <= bus.cpu_to_mem__data;
                        cnt       <= 4'(LATENCY);
                        ready_q   <= 1'b0;
                        if (LATENCY > 0) begin
                            state <= ST_WAIT;
                        end else begin
                            state   <= ST_RESPOND;
                            valid_q <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd1) begin
                        state   <= ST_RESPOND;
                        valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESPOND: begin
                    state   <= ST_READY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= ST_READY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Access size, alignment and range of the registered request.
    always_comb begin
        size     = 4'd1;
        misalign = 1'b0;
        case (req_dtype)
            3'd0:       begin size = 4'd8; misalign = |req_addr[2:0]; end
            3'd1, 3'd2: begin size = 4'd4; misalign = |req_addr[1:0]; end
            3'd3, 3'd4: begin size = 4'd2; misalign = req_addr[0];    end
            default:    begin size = 4'd1; misalign = 1'b0;           end
        endcase
        idx      = req_addr[AW-1:0];
        size_ext = {{(AW-3){1'b0}}, size};
        end_addr = {1'b0, idx} + size_ext;
        // One past the last byte must not exceed DEPTH; high bits never alias.
        oob      = (|req_addr[63:AW]) || (end_addr > DEPTH_W);
    end

    // Gather eight bytes from the request address and extend per dtype.
    always_comb begin
        raw = 64'd0;
        for (int i = 0; i < 8; i++) begin
            raw[8*i +: 8] = mem[idx + i[AW-1:0]];
        end
        case (req_dtype)
            3'd0:    rd_data = raw;
            3'd1:    rd_data = {{32{raw[31]}}, raw[31:0]};
            3'd2:    rd_data = {32'd0, raw[31:0]};
            3'd3:    rd_data = {{48{raw[15]}}, raw[15:0]};
            3'd4:    rd_data = {48'd0, raw[15:0]};
            3'd5:    rd_data = {{56{raw[7]}}, raw[7:0]};
            3'd6:    rd_data = {56'd0, raw[7:0]};
            default: rd_data = 64'd0;
        endcase
    end

    // Response priority: invalid dtype, misaligned, out of range, success.
    always_comb begin
        resp_err  = 1'b0;
        resp_data = 64'd0;
        if (valid_q) begin
            if (req_dtype == 3'd7) begin
                resp_err  = 1'b1;
                resp_data = 64'h3;
            end else if (misalign) begin
                resp_err  = 1'b1;
                resp_data = 64'h1;
            end else if (oob) begin
                resp_err  = 1'b1;
                resp_data = 64'h2;
            end else if (!req_we) begin
                resp_data = rd_data;
            end
        end
    end

    // Commit a successful write at the edge that ends RESPOND; reset clears
    // valid_q asynchronously, so a pending write is dropped.
    always_ff @(posedge clk) begin
        if (valid_q && req_we && !resp_err) begin
            for (int i = 0; i < 8; i++) begin
                if (i[3:0] < size) begin
                    mem[idx + i[AW-1:0]] <= req_data[8*i +: 8];
                end
            end
        end
    end

    assign bus.mem_to_cpu__ready = ready_q;
    assign bus.mem_to_cpu__valid = valid_q;
    assign bus.mem_to_cpu__error = resp_err;
    assign bus.mem_to_cpu__data  = resp_data;
    assign dbg_state             = state;

endmodule
